game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter START_LIVES, default 3, lives loaded at game start (1..7).
REQ-002 Parameter POINTS_PER_BLOCK, default 10, score added per brick cleared.
REQ-003 Parameter CLEAR_DELAY, default 60, frames spent in LEVEL_CLEAR before the next level loads.
REQ-004 Parameter SCORE_MAX, default 9999, score saturation value.
REQ-005 frame_clk  in  1  frame clock; all state updates on posedge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 keycode  in  8  current USB keycode; 0x2C = Space.
REQ-008 Blocks  in  32  live brick bitmap returned by the ball engine; 1 = brick present.
REQ-009 Bar_Reset  in  1  ball-engine life-lost/serve indication.
REQ-010 Block_Array  out  32  brick pattern for the current level, loaded by the ball engine on Level_Load.
REQ-011 Level_Load  out  1  one-frame pulse; drives the ball engine's reset so it reloads Block_Array and re-serves.
REQ-012 Score  out  14  running score, binary, saturating.
REQ-013 Lives  out  3  remaining lives.
REQ-014 Level  out  3  current level, 0-based.
REQ-015 Game_State  out  2  IDLE=0, PLAY=1, LEVEL_CLEAR=2, GAME_OVER=3.

Function
REQ-016 FSM states: IDLE, PLAY, LEVEL_CLEAR, GAME_OVER; one transition max per frame.
REQ-017 IDLE -> PLAY on keycode==0x2C: Score<=0, Lives<=START_LIVES, Level<=0, Level_Load pulses that frame.
REQ-018 Block_Array = LEVEL_PATTERN[Level[1:0]] combinationally at all times.
REQ-019 Register prev_blocks <= Block_Array on every Level_Load frame, else <= Blocks while in PLAY.
REQ-020 Cleared count = popcount(prev_blocks & ~Blocks), range 0..32, evaluated only in PLAY and not on Level_Load frames.
REQ-021 Score <= min(Score + count*POINTS_PER_BLOCK, SCORE_MAX); intermediate sum at least 16 bits wide, no wrap.
REQ-022 Life lost = rising edge of Bar_Reset (registered Bar_Reset_d, cleared by Level_Load) while in PLAY.
REQ-023 Life lost with Lives>1: Lives decrements, state stays PLAY.
REQ-024 Life lost with Lives==1: Lives<=0, state -> GAME_OVER.
REQ-025 PLAY -> LEVEL_CLEAR when Blocks==0 after the frame's score update; delay counter loads CLEAR_DELAY.
REQ-026 Blocks==0 and life lost in the same frame: LEVEL_CLEAR wins, Lives unchanged, score still credited.
REQ-027 LEVEL_CLEAR: counter decrements each frame; at 0 -> PLAY, Level<=Level+1 (saturates at 7), Level_Load pulses.
REQ-028 GAME_OVER: Score, Level held; restart arms only after a frame with keycode!=0x2C, then 0x2C -> IDLE->PLAY sequence of REQ-017 in one transition.
REQ-029 Level_Load is high exactly one frame per load; never high two consecutive frames.
REQ-030 Game_State output equals the registered FSM state.

Reset
REQ-031 On Reset: state IDLE, Score 0, Lives START_LIVES, Level 0, Level_Load 1, delay counter 0, prev_blocks LEVEL_PATTERN[0], Bar_Reset_d 1, restart arm 0.
REQ-032 Reset mid-game aborts any state immediately; first frame after release Level_Load returns to 0.

Structure
REQ-033 Shared package game_pkg holds the state enum, LEVEL_PATTERN[0:3] 32-bit constants, and key codes KEY_SPACE=0x2C.
REQ-034 One sub-module popcount32 (combinational 32-bit population count, 6-bit result).

Verification
REQ-035 Reset, Space for one frame -> Game_State=1, Lives=3, Level_Load high that frame only, Block_Array=LEVEL_PATTERN[0].
REQ-036 In PLAY, Blocks drops 3 bits in one frame -> Score +30 next frame; Score=9990 and 2 bits drop -> Score=9999.
REQ-037 Bar_Reset held high 5 frames -> Lives decrements by exactly 1; three separate edges from Lives=3 -> Lives=0, Game_State=3.
REQ-038 Blocks -> 0 with Bar_Reset edge same frame -> Game_State=2, Lives unchanged; after 60 frames Level=1, Level_Load pulse, Block_Array=LEVEL_PATTERN[1].
REQ-039 GAME_OVER with Space held continuously -> stays GAME_OVER; release one frame then Space -> PLAY, Score=0, Lives=3.
REQ-040 Reset asserted during LEVEL_CLEAR countdown -> all outputs at REQ-031 values, no Level increment.

Source files
------------

// File: rtl/game_pkg.sv
// +--------------------------------------------------------------------------+
// | game_pkg : shared FSM encoding, level brick patterns and key codes         |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_PLAY        = 2'd1,
      ST_LEVEL_CLEAR = 2'd2,
      ST_GAME_OVER   = 2'd3
   } game_state_t;

   localparam logic [7:0] KEY_SPACE = 8'h2C;

   // Level index wraps through four layouts; level 0 is a full wall.
   localparam logic [31:0] LEVEL_PATTERN [0:3] = '{
      32'hFFFF_FFFF,
      32'hAAAA_5555,
      32'h0F0F_F0F0,
      32'h3C3C_C3C3
   };

   function automatic logic [2:0] level_inc(input logic [2:0] lvl);
      return (lvl == 3'd7) ? 3'd7 : lvl + 3'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/game_ctrl_popcount32.sv
// +--------------------------------------------------------------------------+
// | popcount32 : combinational 32-bit population count                         |
// | Revision   : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module popcount32 (
   input  logic [31:0] bits,
   output logic [5:0]  count
);

   always_comb begin
      count = 6'd0;
      for (int i = 0; i < 32; i++) begin
         count = count + {5'd0, bits[i]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// +--------------------------------------------------------------------------+
// | game_ctrl : breakout game flow - score, lives, levels and level reloads    |
// | Revision  : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module game_ctrl
   import game_pkg::*;
#(
   parameter int START_LIVES      = 3,
   parameter int POINTS_PER_BLOCK = 10,
   parameter int CLEAR_DELAY      = 60,
   parameter int SCORE_MAX        = 9999
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [7:0]  keycode,
   input  logic [31:0] Blocks,
   input  logic        Bar_Reset,
   output logic [31:0] Block_Array,
   output logic        Level_Load,
   output logic [13:0] Score,
   output logic [2:0]  Lives,
   output logic [2:0]  Level,
   output logic [1:0]  Game_State
);

   localparam int DELAY_W = (CLEAR_DELAY < 2) ? 1 : $clog2(CLEAR_DELAY + 1);

   game_state_t        r_state;
   logic [31:0]        r_prev_blocks;
   logic               r_bar_d;
   logic               r_arm;
   logic [DELAY_W-1:0] r_delay;

   logic [5:0]         w_count;
   logic [31:0]        w_sum;
   logic [13:0]        w_score_next;
   logic               w_space;
   logic               w_start;
   logic               w_life_lost;
   logic               w_eval;

   popcount32 u_popcount (
      .bits  (r_prev_blocks & ~Blocks),
      .count (w_count)
   );

   assign Block_Array = LEVEL_PATTERN[Level[1:0]];
   assign Game_State  = r_state;

   // Wide sum so a large brick count near the ceiling saturates instead of wrapping.
   assign w_sum        = {18'd0, Score} + 32'(w_count) * 32'(POINTS_PER_BLOCK);
   assign w_score_next = (w_sum > 32'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_sum[13:0];

   assign w_space     = (keycode == KEY_SPACE);
   assign w_start     = w_space && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_GAME_OVER) && r_arm));
   assign w_life_lost = (r_state == ST_PLAY) && Bar_Reset && !r_bar_d;
   // Blocks is stale during a load frame, so scoring and clear detection skip it.
   assign w_eval      = (r_state == ST_PLAY) && !Level_Load;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_state       <= ST_IDLE;
         Score         <= 14'd0;
         Lives         <= 3'(START_LIVES);
         Level         <= 3'd0;
         Level_Load    <= 1'b1;
         r_delay       <= '0;
         r_prev_blocks <= LEVEL_PATTERN[0];
         r_bar_d       <= 1'b1;
         r_arm         <= 1'b0;
      end else begin
         Level_Load <= 1'b0;

         if (Level_Load) begin
            r_prev_blocks <= Block_Array;
            r_bar_d       <= 1'b0;
         end else begin
            if (r_state == ST_PLAY) begin
               r_prev_blocks <= Blocks;
            end
            r_bar_d <= Bar_Reset;
         end

         if (w_start) begin
            r_state    <= ST_PLAY;
            Score      <= 14'd0;
            Lives      <= 3'(START_LIVES);
            Level      <= 3'd0;
            Level_Load <= 1'b1;
            r_arm      <= 1'b0;
         end else begin
            case (r_state)
               ST_PLAY: begin
                  if (w_eval) begin
                     Score <= w_score_next;
                  end
                  // Clearing the wall takes priority over a simultaneous lost ball.
                  if (w_eval && (Blocks == 32'd0)) begin
                     r_state <= ST_LEVEL_CLEAR;
                     r_delay <= DELAY_W'(CLEAR_DELAY);
                  end else if (w_life_lost) begin
                     if (Lives > 3'd1) begin
                        Lives <= Lives - 3'd1;
                     end else begin
                        Lives   <= 3'd0;
                        r_state <= ST_GAME_OVER;
                        r_arm   <= 1'b0;
                     end
                  end
               end
               ST_LEVEL_CLEAR: begin
                  if (r_delay <= DELAY_W'(1)) begin
                     r_delay    <= '0;
                     r_state    <= ST_PLAY;
                     Level      <= level_inc(Level);
                     Level_Load <= 1'b1;
                  end else begin
                     r_delay <= r_delay - DELAY_W'(1);
                  end
               end
               ST_GAME_OVER: begin
                  if (!w_space) begin
                     r_arm <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_game_ctrl : directed self-checking bench for game_ctrl                  |
// | Revision     : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_game_ctrl;
   import game_pkg::*;

   logic        frame_clk = 1'b0;
   logic        Reset;
   logic [7:0]  keycode;
   logic [31:0] Blocks;
   logic        Bar_Reset;
   logic [31:0] Block_Array;
   logic        Level_Load;
   logic [13:0] Score;
   logic [2:0]  Lives;
   logic [2:0]  Level;
   logic [1:0]  Game_State;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] pat0;
   logic [31:0] pat1;

   game_ctrl dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .Blocks      (Blocks),
      .Bar_Reset   (Bar_Reset),
      .Block_Array (Block_Array),
      .Level_Load  (Level_Load),
      .Score       (Score),
      .Lives       (Lives),
      .Level       (Level),
      .Game_State  (Game_State)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; keycode = 8'h00; Blocks = pat0; Bar_Reset = 1'b0;
      step(); step();
      vectors++; if (Game_State !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", Game_State); end
      vectors++; if (Score !== 14'd0) begin errors++; $display("FAIL rst_score got=%0d exp=0", Score); end
      vectors++; if (Lives !== 3'd3) begin errors++; $display("FAIL rst_lives got=%0d exp=3", Lives); end
      vectors++; if (Level_Load !== 1'b1) begin errors++; $display("FAIL rst_load got=%0b exp=1", Level_Load); end
      Reset = 1'b0;
      step();
      vectors++; if (Level_Load !== 1'b0) begin errors++; $display("FAIL rst_release_load got=%0b exp=0", Level_Load); end
      vectors++; if (Game_State !== 2'd0) begin errors++; $display("FAIL idle_hold got=%0d exp=0", Game_State); end
   endtask

   task automatic test_start();
      keycode = KEY_SPACE;
      step();
      keycode = 8'h00;
      vectors++; if (Game_State !== 2'd1) begin errors++; $display("FAIL start_state got=%0d exp=1", Game_State); end
      vectors++; if (Lives !== 3'd3) begin errors++; $display("FAIL start_lives got=%0d exp=3", Lives); end
      vectors++; if (Level_Load !== 1'b1) begin errors++; $display("FAIL start_load got=%0b exp=1", Level_Load); end
      vectors++; if (Block_Array !== pat0) begin errors++; $display("FAIL start_pattern got=%h exp=%h", Block_Array, pat0); end
      step();
      vectors++; if (Level_Load !== 1'b0) begin errors++; $display("FAIL start_load_drop got=%0b exp=0", Level_Load); end
   endtask

   task automatic test_score();
      Blocks = 32'hFFFF_FFF8;
      step();
      vectors++; if (Score !== 14'd30) begin errors++; $display("FAIL score_3bits got=%0d exp=30", Score); end
      step();
      vectors++; if (Score !== 14'd30) begin errors++; $display("FAIL score_steady got=%0d exp=30", Score); end
   endtask

   task automatic test_level_clear();
      // 29 bricks remain; wall cleared together with a Bar_Reset edge
      Blocks = 32'h0; Bar_Reset = 1'b1;
      step();
      Bar_Reset = 1'b0;
      vectors++; if (Game_State !== 2'd2) begin errors++; $display("FAIL clr_state got=%0d exp=2", Game_State); end
      vectors++; if (Lives !== 3'd3) begin errors++; $display("FAIL clr_lives got=%0d exp=3", Lives); end
      vectors++; if (Score !== 14'd320) begin errors++; $display("FAIL clr_score got=%0d exp=320", Score); end
      for (int i = 0; i < 59; i++) step();
      vectors++; if (Game_State !== 2'd2) begin errors++; $display("FAIL clr_frame60 got=%0d exp=2", Game_State); end
      vectors++; if (Level !== 3'd0) begin errors++; $display("FAIL clr_level_hold got=%0d exp=0", Level); end
      step();
      vectors++; if (Game_State !== 2'd1) begin errors++; $display("FAIL clr_resume got=%0d exp=1", Game_State); end
      vectors++; if (Level !== 3'd1) begin errors++; $display("FAIL clr_level got=%0d exp=1", Level); end
      vectors++; if (Level_Load !== 1'b1) begin errors++; $display("FAIL clr_load got=%0b exp=1", Level_Load); end
      vectors++; if (Block_Array !== pat1) begin errors++; $display("FAIL clr_pattern got=%h exp=%h", Block_Array, pat1); end
      Blocks = pat1;
      step();
      vectors++; if (Level_Load !== 1'b0) begin errors++; $display("FAIL clr_load_drop got=%0b exp=0", Level_Load); end
      vectors++; if (Score !== 14'd320) begin errors++; $display("FAIL clr_score_hold got=%0d exp=320", Score); end
   endtask

   task automatic test_saturate();
      // 31 bricks per round trip: 320 + 31*310 = 9930
      for (int i = 0; i < 31; i++) begin
         Blocks = 32'hFFFF_FFFF; step();
         Blocks = 32'h0000_0001; step();
      end
      vectors++; if (Score !== 14'd9930) begin errors++; $display("FAIL sat_ramp got=%0d exp=9930", Score); end
      Blocks = 32'hFFFF_FFFF; step();
      Blocks = 32'hFFFF_FFC0; step();
      vectors++; if (Score !== 14'd9990) begin errors++; $display("FAIL sat_9990 got=%0d exp=9990", Score); end
      Blocks = 32'hFFFF_FF00; step();
      vectors++; if (Score !== 14'd9999) begin errors++; $display("FAIL sat_clip got=%0d exp=9999", Score); end
   endtask

   task automatic test_lives();
      Bar_Reset = 1'b1;
      for (int i = 0; i < 5; i++) step();
      vectors++; if (Lives !== 3'd2) begin errors++; $display("FAIL life_hold5 got=%0d exp=2", Lives); end
      Bar_Reset = 1'b0; step();
      Bar_Reset = 1'b1; step();
      vectors++; if (Lives !== 3'd1) begin errors++; $display("FAIL life_edge2 got=%0d exp=1", Lives); end
      vectors++; if (Game_State !== 2'd1) begin errors++; $display("FAIL life_still_play got=%0d exp=1", Game_State); end
      Bar_Reset = 1'b0; step();
      Bar_Reset = 1'b1; step();
      Bar_Reset = 1'b0;
      vectors++; if (Lives !== 3'd0) begin errors++; $display("FAIL life_edge3 got=%0d exp=0", Lives); end
      vectors++; if (Game_State !== 2'd3) begin errors++; $display("FAIL game_over got=%0d exp=3", Game_State); end
   endtask

   task automatic test_restart();
      keycode = KEY_SPACE;
      for (int i = 0; i < 4; i++) step();
      vectors++; if (Game_State !== 2'd3) begin errors++; $display("FAIL go_space_held got=%0d exp=3", Game_State); end
      vectors++; if (Score !== 14'd9999) begin errors++; $display("FAIL go_score_hold got=%0d exp=9999", Score); end
      vectors++; if (Level !== 3'd1) begin errors++; $display("FAIL go_level_hold got=%0d exp=1", Level); end
      keycode = 8'h00; step();
      vectors++; if (Game_State !== 2'd3) begin errors++; $display("FAIL go_arm got=%0d exp=3", Game_State); end
      keycode = KEY_SPACE; step();
      keycode = 8'h00;
      vectors++; if (Game_State !== 2'd1) begin errors++; $display("FAIL restart_state got=%0d exp=1", Game_State); end
      vectors++; if (Score !== 14'd0) begin errors++; $display("FAIL restart_score got=%0d exp=0", Score); end
      vectors++; if (Lives !== 3'd3) begin errors++; $display("FAIL restart_lives got=%0d exp=3", Lives); end
      vectors++; if (Level !== 3'd0) begin errors++; $display("FAIL restart_level got=%0d exp=0", Level); end
      vectors++; if (Level_Load !== 1'b1) begin errors++; $display("FAIL restart_load got=%0b exp=1", Level_Load); end
      Blocks = pat0; step();
      vectors++; if (Level_Load !== 1'b0) begin errors++; $display("FAIL restart_load_drop got=%0b exp=0", Level_Load); end
   endtask

   task automatic test_reset_in_clear();
      Blocks = 32'h0; step();
      vectors++; if (Game_State !== 2'd2) begin errors++; $display("FAIL rlc_enter got=%0d exp=2", Game_State); end
      vectors++; if (Score !== 14'd320) begin errors++; $display("FAIL rlc_score got=%0d exp=320", Score); end
      for (int i = 0; i < 10; i++) step();
      #2 Reset = 1'b1;
      #1;
      vectors++; if (Game_State !== 2'd0) begin errors++; $display("FAIL rlc_state got=%0d exp=0", Game_State); end
      vectors++; if (Score !== 14'd0) begin errors++; $display("FAIL rlc_score0 got=%0d exp=0", Score); end
      vectors++; if (Lives !== 3'd3) begin errors++; $display("FAIL rlc_lives got=%0d exp=3", Lives); end
      vectors++; if (Level_Load !== 1'b1) begin errors++; $display("FAIL rlc_load got=%0b exp=1", Level_Load); end
      vectors++; if (Block_Array !== pat0) begin errors++; $display("FAIL rlc_pattern got=%h exp=%h", Block_Array, pat0); end
      step(); step();
      Reset = 1'b0; Blocks = pat0;
      step();
      vectors++; if (Level !== 3'd0) begin errors++; $display("FAIL rlc_level got=%0d exp=0", Level); end
      vectors++; if (Level_Load !== 1'b0) begin errors++; $display("FAIL rlc_release_load got=%0b exp=0", Level_Load); end
      vectors++; if (Game_State !== 2'd0) begin errors++; $display("FAIL rlc_idle got=%0d exp=0", Game_State); end
   endtask

   initial begin
      pat0 = 32'hFFFF_FFFF;
      pat1 = 32'hAAAA_5555;
      test_reset();
      test_start();
      test_score();
      test_level_clear();
      test_saturate();
      test_lives();
      test_restart();
      test_reset_in_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
